// File: rtl/vxc_axpy_stream.sv
// vxc_axpy_stream
// Streaming vector update unit. It computes r = x + c*y, x - c*y, c*y or
// y + c*x over a vector of `total` fixed-point elements. The vector arrives
// in chunks of NO_OF_UNITS lanes.
//
// Ports:
//   clk, reset        - rising-edge clock; asynchronous active-high reset
//   start             - one-cycle request, only honoured in IDLE
//   total             - element count, latched on accepted start
//   constant, op      - scale c and mode, latched on accepted start
//   in_valid/in_ready - input chunk handshake (first_row = x, second_row = y)
//   result*           - output chunk, valid/ready handshake, chunk address,
//                       lane mask
//   result_mem_we     - write strobe, high when a result is accepted
//   busy, finish      - activity flag and end-of-vector pulse
//   overflow          - sticky saturation flag since the last accepted start
module vxc_axpy_stream #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int FRAC_BITS     = 16,
  parameter int NO_OF_UNITS   = 8,
  parameter int ADDR_W        = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [31:0]                           total,
  input  logic [ELEMENT_WIDTH-1:0]              constant,
  input  logic [1:0]                            op,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  first_row,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  second_row,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  result,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  result_mem_we,
  output logic [ADDR_W-1:0]                     result_addr,
  output logic [NO_OF_UNITS-1:0]                result_lane_mask,
  output logic                                  busy,
  output logic                                  finish,
  output logic                                  overflow
);

  localparam int W  = ELEMENT_WIDTH;
  localparam int NI = NO_OF_UNITS;
  localparam int PW = 2 * W;

  // Saturation bounds expressed in the (2W+1)-bit sum domain.
  localparam logic signed [PW:0] SAT_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [31:0]            total_q;
  logic [31:0]            num_chunks;
  logic signed [W-1:0]    const_q;
  logic [1:0]             op_q;
  logic [ADDR_W-1:0]      in_cnt;

  logic stall, advance, start_acc, accept, last_in, last_out;

  // A held output freezes the whole pipeline, so nothing is ever overwritten.
  assign stall         = result_valid && !result_ready;
  assign advance       = !stall;
  assign start_acc     = start && (state == IDLE);
  assign in_ready      = (state == RUN) && !stall;
  assign accept        = in_valid && in_ready;
  assign result_mem_we = result_valid && result_ready;
  assign busy          = (state != IDLE);
  assign finish        = (state == DONE);
  assign last_in       = (32'(in_cnt) + 32'd1) == num_chunks;
  assign last_out      = (32'(result_addr) + 32'd1) == num_chunks;

  // Job parameters, chunk counters and the FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      total_q     <= '0;
      num_chunks  <= '0;
      const_q     <= '0;
      op_q        <= '0;
      in_cnt      <= '0;
      result_addr <= '0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        total_q     <= total;
        num_chunks  <= (total / NI) + 32'((total % NI) != 0);
        const_q     <= constant;
        op_q        <= op;
        in_cnt      <= '0;
        result_addr <= '0;
      end else begin
        if (accept)        in_cnt      <= in_cnt + ADDR_W'(1);
        if (result_mem_we) result_addr <= result_addr + ADDR_W'(1);
      end
    end
  end

  // Next-state logic. RUN ends on the last input chunk. DRAIN ends when the
  // last result is written.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (total == 32'd0) ? DONE : RUN;
      RUN:     if (accept && last_in) state_next = DRAIN;
      DRAIN:   if (result_mem_we && last_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane mask for the chunk being accepted. 64-bit math avoids wrap for huge totals.
  logic [NI-1:0] mask_in;
  always_comb begin
    mask_in = '0;
    for (int i = 0; i < NI; i++)
      mask_in[i] = (64'(in_cnt) * 64'(NI) + 64'(i)) < 64'(total_q);
  end

  // Stage 1: operand and mask capture.
  logic                s1_valid;
  logic [NI-1:0]       s1_mask;
  logic signed [W-1:0] s1_x [NI];
  logic signed [W-1:0] s1_y [NI];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      for (int i = 0; i < NI; i++) begin
        s1_x[i] <= '0;
        s1_y[i] <= '0;
      end
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_mask <= mask_in;
        for (int i = 0; i < NI; i++) begin
          s1_x[i] <= first_row[W*i +: W];
          s1_y[i] <= second_row[W*i +: W];
        end
      end
    end
  end

  // Stage 2 inputs. Mode 11 multiplies x and adds y. Mode 10 adds nothing.
  logic signed [PW-1:0] c_ext;
  logic signed [PW-1:0] m_ext;
  logic signed [PW-1:0] prod_in [NI];
  logic signed [W-1:0]  add_in  [NI];

  always_comb begin
    c_ext = const_q;
    m_ext = '0;
    for (int i = 0; i < NI; i++) begin
      m_ext      = (op_q == 2'b11) ? s1_x[i] : s1_y[i];
      prod_in[i] = c_ext * m_ext;
      case (op_q)
        2'b00, 2'b01: add_in[i] = s1_x[i];
        2'b10:        add_in[i] = '0;
        default:      add_in[i] = s1_y[i];
      endcase
    end
  end

  // Stage 2: full-width product register.
  logic                 s2_valid;
  logic [NI-1:0]        s2_mask;
  logic signed [PW-1:0] s2_p [NI];
  logic signed [W-1:0]  s2_a [NI];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_mask  <= '0;
      for (int i = 0; i < NI; i++) begin
        s2_p[i] <= '0;
        s2_a[i] <= '0;
      end
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mask <= s1_mask;
        for (int i = 0; i < NI; i++) begin
          s2_p[i] <= prod_in[i];
          s2_a[i] <= add_in[i];
        end
      end
    end
  end

  // Stage 3 logic: shift back to F fractional bits, then add or subtract,
  // then saturate. Masked-off lanes are forced to zero and never saturate.
  logic signed [PW-1:0]   shifted;
  logic signed [PW:0]     a_ext, s_ext, sum;
  logic [W*NI-1:0]        result_next;
  logic                   sat_any;

  always_comb begin
    shifted     = '0;
    a_ext       = '0;
    s_ext       = '0;
    sum         = '0;
    result_next = '0;
    sat_any     = 1'b0;
    for (int i = 0; i < NI; i++) begin
      shifted = s2_p[i] >>> FRAC_BITS;
      a_ext   = s2_a[i];
      s_ext   = shifted;
      sum     = (op_q == 2'b01) ? (a_ext - s_ext) : (a_ext + s_ext);
      if (s2_mask[i]) begin
        if (sum > SAT_MAX) begin
          result_next[W*i +: W] = SAT_MAX[W-1:0];
          sat_any               = 1'b1;
        end else if (sum < SAT_MIN) begin
          result_next[W*i +: W] = SAT_MIN[W-1:0];
          sat_any               = 1'b1;
        end else begin
          result_next[W*i +: W] = sum[W-1:0];
        end
      end
    end
  end

  // Stage 3: output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid     <= 1'b0;
      result           <= '0;
      result_lane_mask <= '0;
    end else if (advance) begin
      result_valid <= s2_valid;
      if (s2_valid) begin
        result           <= result_next;
        result_lane_mask <= s2_mask;
      end
    end
  end

  // Sticky overflow flag. It is cleared only by a new accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (start_acc)
      overflow <= 1'b0;
    else if (advance && s2_valid && sat_any)
      overflow <= 1'b1;
  end

endmodule

// File: tb/tb_vxc_axpy_stream.sv
// tb_vxc_axpy_stream
// Self-checking bench for vxc_axpy_stream (W=32, F=16, NI=8, ADDR_W=16).
// Each accepted chunk pushes a modelled result onto a scoreboard queue. A
// forked monitor pops the queue on every result write and compares the
// values. It also checks that results stay stable while stalled.
module tb_vxc_axpy_stream;

  localparam int W  = 32;
  localparam int NI = 8;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [31:0]     total;
  logic [W-1:0]    constant;
  logic [1:0]      op;
  logic            in_valid;
  logic            in_ready;
  logic [W*NI-1:0] first_row;
  logic [W*NI-1:0] second_row;
  logic [W*NI-1:0] result;
  logic            result_valid;
  logic            result_ready;
  logic            result_mem_we;
  logic [AW-1:0]   result_addr;
  logic [NI-1:0]   result_lane_mask;
  logic            busy;
  logic            finish;
  logic            overflow;

  vxc_axpy_stream #(
    .ELEMENT_WIDTH(W), .FRAC_BITS(16), .NO_OF_UNITS(NI), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .total(total),
    .constant(constant), .op(op), .in_valid(in_valid), .in_ready(in_ready),
    .first_row(first_row), .second_row(second_row), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_mem_we(result_mem_we), .result_addr(result_addr),
    .result_lane_mask(result_lane_mask), .busy(busy), .finish(finish),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W*NI-1:0] res;
    logic [NI-1:0]   mask;
    logic [AW-1:0]   addr;
  } exp_t;

  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc = 0;
  int writes = 0;
  int finish_count = 0;
  int last_we_cyc = 0;
  int finish_cyc = 0;
  int first_accept_cyc = 0;
  int first_valid_cyc = 0;
  bit seen_valid = 0;
  bit rand_mode = 0;
  logic [W*NI-1:0] last_result = '0;
  logic [NI-1:0]   last_mask = '0;

  logic [1:0]  cur_op;
  logic [31:0] cur_c;
  logic [31:0] cur_total;
  int          chunk_idx;

  task automatic checkOutput(input string tag, input logic [W*NI-1:0] obs,
                             input logic [W*NI-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model for a single lane. It uses 64-bit longint arithmetic.
  function automatic logic [31:0] lane_model(input logic [1:0] o, input logic [31:0] c,
                                             input logic [31:0] x, input logic [31:0] y);
    longint cv, mv, av, p, s;
    cv = $signed(c);
    mv = (o == 2'b11) ? $signed(x) : $signed(y);
    case (o)
      2'b00, 2'b01: av = $signed(x);
      2'b10:        av = 0;
      default:      av = $signed(y);
    endcase
    p = (cv * mv) >>> 16;
    s = (o == 2'b01) ? av - p : av + p;
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[31:0];
  endfunction

  function automatic exp_t build_expected(input logic [W*NI-1:0] xv,
                                          input logic [W*NI-1:0] yv);
    exp_t e;
    longint elem;
    e.res  = '0;
    e.mask = '0;
    e.addr = AW'(chunk_idx);
    for (int i = 0; i < NI; i++) begin
      elem = longint'(chunk_idx) * NI + i;
      if (elem < longint'(cur_total)) begin
        e.mask[i]      = 1'b1;
        e.res[W*i +: W] = lane_model(cur_op, cur_c, xv[W*i +: W], yv[W*i +: W]);
      end
    end
    return e;
  endfunction

  task automatic run_cycle_count();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic run_ready();
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) result_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    bit stall_prev = 0;
    logic [W*NI-1:0] prev_res = '0;
    logic [AW-1:0]   prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 0;
      end else begin
        if (result_valid && !seen_valid) begin
          seen_valid      = 1;
          first_valid_cyc = cyc;
        end
        if (stall_prev && result_valid) begin
          checkOutput("stall_hold_result", result, prev_res);
          checkOutput("stall_hold_addr", W*NI'(result_addr), W*NI'(prev_addr));
        end
        stall_prev = result_valid && !result_ready;
        prev_res   = result;
        prev_addr  = result_addr;
        if (result_valid && result_ready) begin
          writes++;
          last_we_cyc = cyc;
          last_result = result;
          last_mask   = result_lane_mask;
          compared++;
          assert (sb.size() > 0) else begin
            mismatched++;
            $error("[TB] FAIL unexpected_write addr=%0d observed=write expected=none", result_addr);
          end
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("result_addr", W*NI'(result_addr), W*NI'(e.addr));
            checkOutput("lane_mask", W*NI'(result_lane_mask), W*NI'(e.mask));
            checkOutput("mem_we", W*NI'(result_mem_we), W*NI'(1'b1));
          end
        end
        if (finish) begin
          finish_count++;
          finish_cyc = cyc;
        end
      end
    end
  endtask

  // Pulse start with the given job parameters, then scramble the job inputs.
  task automatic applyStimulus(input logic [31:0] t, input logic [31:0] c,
                               input logic [1:0] o);
    start     = 1'b1;
    total     = t;
    constant  = c;
    op        = o;
    cur_total = t;
    cur_c     = c;
    cur_op    = o;
    chunk_idx = 0;
    seen_valid = 0;
    @(posedge clk); #1;
    start    = 1'b0;
    total    = $urandom;
    constant = $urandom;
    op       = 2'($urandom_range(0, 3));
  endtask

  task automatic send_chunk(input logic [W*NI-1:0] xv, input logic [W*NI-1:0] yv);
    bit got = 0;
    in_valid   = 1'b1;
    first_row  = xv;
    second_row = yv;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        sb.push_back(build_expected(xv, yv));
        if (chunk_idx == 0) first_accept_cyc = cyc;
        chunk_idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    compared++;
    assert (got === 1'b1) else begin
      mismatched++;
      $error("[TB] FAIL chunk_accept_timeout observed=%0d expected=1", got);
    end
  endtask

  task automatic wait_finish(input int f0);
    for (int k = 0; k < 2000 && finish_count == f0; k++) @(negedge clk);
    compared++;
    assert (finish_count === f0 + 1) else begin
      mismatched++;
      $error("[TB] FAIL finish_wait observed=%0d expected=%0d", finish_count, f0 + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [31:0] t, input logic [31:0] c, input logic [1:0] o,
                         input logic [31:0] xs, input logic [31:0] ys);
    int f0, w0, n;
    f0 = finish_count;
    w0 = writes;
    n  = (t + NI - 1) / NI;
    applyStimulus(t, c, o);
    for (int k = 0; k < n; k++) send_chunk({NI{xs}}, {NI{ys}});
    wait_finish(f0);
    checkOutput("write_count", W*NI'(writes - w0), W*NI'(n));
    checkOutput("scoreboard_empty", W*NI'(sb.size()), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_in_ready"}, W*NI'(in_ready), '0);
    checkOutput({tag, "_result"}, result, '0);
    checkOutput({tag, "_result_valid"}, W*NI'(result_valid), '0);
    checkOutput({tag, "_mem_we"}, W*NI'(result_mem_we), '0);
    checkOutput({tag, "_addr"}, W*NI'(result_addr), '0);
    checkOutput({tag, "_mask"}, W*NI'(result_lane_mask), '0);
    checkOutput({tag, "_busy"}, W*NI'(busy), '0);
    checkOutput({tag, "_finish"}, W*NI'(finish), '0);
    checkOutput({tag, "_overflow"}, W*NI'(overflow), '0);
  endtask

  initial begin
    int f0, w0;
    logic [W*NI-1:0] xr, yr;
    reset = 1'b1; start = 1'b0; total = '0; constant = '0; op = '0;
    in_valid = 1'b0; first_row = '0; second_row = '0; result_ready = 1'b1;
    fork
      run_cycle_count();
      run_ready();
      run_monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic add: 1.0 + 2.0*0.5, then latency and finish timing.
    run_job(16, 32'h0002_0000, 2'b00, 32'h0001_0000, 32'h0000_8000);
    checkOutput("op00_value", last_result, {NI{32'h0002_0000}});
    checkOutput("latency", W*NI'(first_valid_cyc), W*NI'(first_accept_cyc + 3));
    checkOutput("finish_after_we", W*NI'(finish_cyc), W*NI'(last_we_cyc + 1));
    checkOutput("op00_no_overflow", W*NI'(overflow), '0);

    run_job(16, 32'h0002_0000, 2'b01, 32'h0001_0000, 32'h0000_8000);
    checkOutput("op01_value", last_result, '0);
    run_job(16, 32'h0002_0000, 2'b10, 32'h0001_0000, 32'h0000_8000);
    checkOutput("op10_value", last_result, {NI{32'h0001_0000}});
    run_job(16, 32'h0002_0000, 2'b11, 32'h0001_0000, 32'h0000_8000);
    checkOutput("op11_value", last_result, {NI{32'h0002_8000}});

    // Partial last chunk, with an extra start issued while busy.
    f0 = finish_count;
    w0 = writes;
    applyStimulus(20, 32'h0002_0000, 2'b00);
    @(negedge clk);
    checkOutput("busy_in_run", W*NI'(busy), W*NI'(1'b1));
    @(posedge clk); #1;
    start = 1'b1; total = 32'd0; op = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) send_chunk({NI{32'h0001_0000}}, {NI{32'h0000_8000}});
    wait_finish(f0);
    checkOutput("partial_writes", W*NI'(writes - w0), W*NI'(3));
    checkOutput("partial_mask", W*NI'(last_mask), W*NI'(8'h0F));
    checkOutput("partial_upper_zero", W*NI'(last_result[W*NI-1:W*4]), '0);
    checkOutput("partial_lower", W*NI'(last_result[W*4-1:0]), W*NI'({4{32'h0002_0000}}));

    // Positive saturation, then the negative mirror with overflow cleared on start.
    run_job(8, 32'h0002_0000, 2'b00, 32'h7FFF_0000, 32'h4000_0000);
    checkOutput("sat_pos_value", last_result, {NI{32'h7FFF_FFFF}});
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat_pos_sticky", W*NI'(overflow), W*NI'(1'b1));
    f0 = finish_count;
    applyStimulus(8, 32'h0002_0000, 2'b01);
    @(negedge clk);
    checkOutput("overflow_cleared", W*NI'(overflow), '0);
    @(posedge clk); #1;
    send_chunk({NI{32'h8001_0000}}, {NI{32'h4000_0000}});
    wait_finish(f0);
    checkOutput("sat_neg_value", last_result, {NI{32'h8000_0000}});
    checkOutput("sat_neg_overflow", W*NI'(overflow), W*NI'(1'b1));

    // Random data with random in_valid gaps and random backpressure.
    f0 = finish_count;
    w0 = writes;
    rand_mode = 1;
    applyStimulus(64, 32'($urandom_range(0, 32'h3FFFF)), 2'($urandom_range(0, 3)));
    for (int k = 0; k < 8; k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < NI; i++) begin
        xr[W*i +: W] = $urandom;
        yr[W*i +: W] = $urandom;
      end
      send_chunk(xr, yr);
    end
    wait_finish(f0);
    rand_mode = 0;
    result_ready = 1'b1;
    checkOutput("random_writes", W*NI'(writes - w0), W*NI'(8));
    checkOutput("random_sb_empty", W*NI'(sb.size()), '0);

    // Reset pulsed mid-vector: abort without a finish pulse.
    applyStimulus(32, 32'h0002_0000, 2'b00);
    send_chunk({NI{32'h0001_0000}}, {NI{32'h0000_8000}});
    send_chunk({NI{32'h0001_0000}}, {NI{32'h0000_8000}});
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    f0 = finish_count;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_no_finish", W*NI'(finish_count), W*NI'(f0));
    checkOutput("abort_idle", W*NI'(busy), '0);
    checkOutput("abort_in_ready", W*NI'(in_ready), '0);

    // Empty vector: one cycle of busy and finish, no writes.
    f0 = finish_count;
    w0 = writes;
    applyStimulus(0, 32'h0002_0000, 2'b00);
    @(negedge clk);
    checkOutput("zero_busy", W*NI'(busy), W*NI'(1'b1));
    checkOutput("zero_finish", W*NI'(finish), W*NI'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("zero_busy_after", W*NI'(busy), '0);
    checkOutput("zero_finish_after", W*NI'(finish), '0);
    checkOutput("zero_finish_count", W*NI'(finish_count), W*NI'(f0 + 1));
    checkOutput("zero_writes", W*NI'(writes), W*NI'(w0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vxc_axpy_stream.md
# vxc_axpy_stream

Parametrised streaming vector-times-constant update unit: r = x ± c·y (plus a c·y and a swapped y + c·x mode), applied to a vector of `total` elements delivered in chunks of NI lanes. It sits between the vector memories and the result memory inside the solver datapath. It is the successor to the fixed 8-lane add/sub wrapper, and adds:
- a real FSM;
- valid/ready handshakes with output backpressure;
- partial-last-chunk masking;
- saturating fixed-point arithmetic;
- result addressing.

## Interface
Parameters:
- ELEMENT_WIDTH, 32, element width W (signed two's complement fixed point)
- FRAC_BITS, 16, fractional bits F of every element and of `constant`
- NO_OF_UNITS, 8, lanes NI per chunk (≥1)
- ADDR_W, 16, width of chunk address/counters

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request, sampled only in IDLE
- total  in  32  element count, latched on accepted start
- constant  in  W  scale c, latched on accepted start
- op  in  2  mode, latched on accepted start: 00 x+c·y, 01 x−c·y, 10 c·y, 11 y+c·x
- in_valid  in  1  chunk present on first_row/second_row
- in_ready  out  1  chunk accepted when in_valid&&in_ready
- first_row  in  W·NI  x chunk; lane i at [W·i +: W]
- second_row  in  W·NI  y chunk, same lane layout
- result  out  W·NI  r chunk, same lane layout
- result_valid  out  1  result/result_addr/result_lane_mask valid
- result_ready  in  1  consumer accepts when result_valid&&result_ready
- result_mem_we  out  1  = result_valid&&result_ready (memory write strobe)
- result_addr  out  ADDR_W  chunk index of current result, 0-based
- result_lane_mask  out  NI  bit i set iff element chunk·NI+i < total
- busy  out  1  state ≠ IDLE
- finish  out  1  one-cycle pulse when the whole vector is written
- overflow  out  1  sticky: any lane saturated since last accepted start

## Operation
- num_chunks = ceil(total/NI), computed on start.
- States:
  - IDLE → RUN on start with total>0. start with total=0 → DONE.
  - RUN: in_ready = pipeline not stalled. After num_chunks chunks are accepted → DRAIN.
  - DRAIN: in_ready=0. When the last result is accepted → DONE.
  - DONE: finish=1 for one cycle → IDLE.
- start outside IDLE is ignored. total/constant/op changes after start are ignored.
- Chunk input counter and chunk output counter are ADDR_W bits, cleared on accepted start. result_addr = output counter.
- Arithmetic per lane:
  - p = c·m as a full 2W-bit signed product, with m = y (modes 00/01/10) or x (mode 11).
  - p >>> F, arithmetic shift (truncation toward −∞).
  - Add a = x (00), −p instead of +p (01), a = 0 (10), a = y (11). Evaluate in 2W+1 bits.
  - Saturate to [−2^(W−1), 2^(W−1)−1]; any clamp sets overflow.
- Lanes with mask bit 0 output 0 and never set overflow.
- Output order equals input order. No chunk is dropped or duplicated under any in_valid/result_ready pattern.

## Timing
- Reset values:
  - in_ready=0, result=0, result_valid=0, result_mem_we=0
  - result_addr=0, result_lane_mask=0
  - busy=0, finish=0, overflow=0, state=IDLE
- Async reset mid-operation aborts immediately. No finish pulse; restart requires a new start.
- Pipeline, 3 register stages:
  - S1: capture operands and mask.
  - S2: multiply.
  - S3: shift, add, saturate; output register.
- Latency: chunk accepted at edge t → result_valid high after edge t+3 when result_ready was held 1.
- Throughput 1 chunk/cycle.
- Stall: result_valid&&!result_ready freezes all stages. in_ready drops in the same cycle (combinational from result_ready). Output holds stable until accepted.
- in_ready is first asserted the cycle after start is accepted.
- finish is asserted the cycle after the last result_mem_we; busy falls with finish.
- Start with total=0: busy and finish high for one cycle, starting the cycle after start; no results.

## Test plan
- W=32, F=16, NI=8, op=00, c=0x00020000, x=0x00010000, y=0x00008000, total=16, result_ready=1 → 2 results of all lanes 0x00020000, addr 0 then 1, mask 0xFF, first valid 3 cycles after the first accept, finish 1 cycle after the second write.
- Same data, op=01 → all lanes 0x00000000. op=10 → 0x00010000. op=11 (y + c·x) → 0x00028000.
- total=20 → 3 chunks, last result_lane_mask=0x0F, lanes 4..7 = 0 even with nonzero inputs.
- op=00, x=0x7FFF0000, y=0x40000000, c=0x00020000 → lanes 0x7FFFFFFF, overflow=1 until next start. Negative mirror (op=01) → 0x80000000.
- Random in_valid/result_ready toggling over total=64 → 8 results in order, addr 0..7, each written exactly once, result held stable while stalled.
- Reset pulsed after 2 of 4 chunks → all outputs at reset values next cycle, no finish. start ignored while busy. total=0 → finish one cycle with no writes.
